// File: rtl/mul_arbiter_seq_pkg.sv
// rtl/mul_arbiter_seq_pkg.sv - shared constants and FSM encoding for the arbitrated multiplier
package mul_arbiter_seq_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_shift_add_core.sv
// rtl/mul_shift_add_core.sv - sign-magnitude shift-add multiply datapath, one iteration per step
module mul_shift_add_core
  import mul_arbiter_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  input  logic               i_signed,
  output logic [2*WIDTH-1:0] o_acc,
  output logic               o_neg
);

  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplr;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_neg;

  // -2^(WIDTH-1) negates to itself, which is still the correct unsigned magnitude
  assign w_a_neg = i_signed & i_a[WIDTH-1];
  assign w_b_neg = i_signed & i_b[WIDTH-1];
  assign w_a_mag = w_a_neg ? -i_a : i_a;
  assign w_b_mag = w_b_neg ? -i_b : i_b;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mcand <= '0;
      r_mplr  <= '0;
      r_acc   <= '0;
      r_neg   <= 1'b0;
    end else if (i_load) begin
      r_mcand <= {{WIDTH{1'b0}}, w_a_mag};
      r_mplr  <= w_b_mag;
      r_acc   <= '0;
      r_neg   <= w_a_neg ^ w_b_neg;
    end else if (i_step) begin
      if (r_mplr[0]) begin
        r_acc <= r_acc + r_mcand;
      end
      r_mcand <= r_mcand << 1;
      r_mplr  <= r_mplr >> 1;
    end
  end

  assign o_acc = r_acc;
  assign o_neg = r_neg;

endmodule

// File: rtl/mul_arbiter_seq.sv
// rtl/mul_arbiter_seq.sv - two-requester round-robin arbiter around a sequential multiplier
module mul_arbiter_seq
  import mul_arbiter_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [1:0]         iReq,
  input  logic [WIDTH-1:0]   iA0,
  input  logic [WIDTH-1:0]   iB0,
  input  logic [WIDTH-1:0]   iA1,
  input  logic [WIDTH-1:0]   iB1,
  input  logic [1:0]         iSigned,
  output logic [1:0]         oGrant,
  output logic               oBusy,
  output logic [2*WIDTH-1:0] oResult,
  output logic [1:0]         oDone
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t             r_state;
  logic [CW-1:0]      r_count;
  logic [1:0]         r_grant;
  logic               r_busy;
  logic [1:0]         r_done;
  logic [2*WIDTH-1:0] r_result;
  logic               r_last;

  logic               w_win1;
  logic               w_load;
  logic               w_step;
  logic               w_last_iter;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic               w_sgn;
  logic [2*WIDTH-1:0] w_acc;
  logic               w_neg;
  logic [2*WIDTH-1:0] w_final;

  // r_last names the requester served most recently; on a tie the other one wins
  assign w_win1      = iReq[1] & (~iReq[0] | ~r_last);
  assign w_a         = w_win1 ? iA1 : iA0;
  assign w_b         = w_win1 ? iB1 : iB0;
  assign w_sgn       = w_win1 ? iSigned[1] : iSigned[0];
  assign w_last_iter = (r_count == CW'(WIDTH));
  assign w_load      = (r_state == ST_IDLE) && (iReq != 2'b00);
  assign w_step      = (r_state == ST_RUN) && !w_last_iter;
  assign w_final     = w_neg ? -w_acc : w_acc;

  mul_shift_add_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .i_clk    (Clock),
    .i_rst_n  (Reset),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_a      (w_a),
    .i_b      (w_b),
    .i_signed (w_sgn),
    .o_acc    (w_acc),
    .o_neg    (w_neg)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_grant  <= 2'b00;
      r_busy   <= 1'b0;
      r_done   <= 2'b00;
      r_result <= '0;
      r_last   <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (iReq != 2'b00) begin
            r_grant <= w_win1 ? 2'b10 : 2'b01;
            r_busy  <= 1'b1;
            r_count <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_last_iter) begin
            r_result <= w_final;
            r_done   <= r_grant;
            r_last   <= r_grant[1];
            r_state  <= ST_DONE;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        ST_DONE: begin
          r_done  <= 2'b00;
          r_grant <= 2'b00;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign oGrant  = r_grant;
  assign oBusy   = r_busy;
  assign oResult = r_result;
  assign oDone   = r_done;

endmodule

// File: tb/tb_mul_arbiter_seq.sv
// tb/tb_mul_arbiter_seq.sv - randomized self-checking bench for mul_arbiter_seq
module tb_mul_arbiter_seq;

  localparam int W   = 16;
  localparam int LAT = W + 2;

  logic          Clock;
  logic          Reset;
  logic [1:0]    iReq;
  logic [W-1:0]  iA0, iB0, iA1, iB1;
  logic [1:0]    iSigned;
  logic [1:0]    oGrant;
  logic          oBusy;
  logic [2*W-1:0] oResult;
  logic [1:0]    oDone;

  int errors = 0;
  int checks = 0;
  int model_last = 1;

  mul_arbiter_seq #(.WIDTH(W)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .iReq    (iReq),
    .iA0     (iA0),
    .iB0     (iB0),
    .iA1     (iA1),
    .iB1     (iB1),
    .iSigned (iSigned),
    .oGrant  (oGrant),
    .oBusy   (oBusy),
    .oResult (oResult),
    .oDone   (oDone)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    longint x;
    longint y;
    x = s ? longint'($signed(a)) : longint'(a);
    y = s ? longint'($signed(b)) : longint'(b);
    return 32'(x * y);
  endfunction

  function automatic int ref_winner(input logic [1:0] req);
    if (req == 2'b01) return 0;
    if (req == 2'b10) return 1;
    return (model_last == 0) ? 1 : 0;
  endfunction

  // Watches one operation from the edge that samples the request until one cycle after oDone.
  task automatic observe(input int drop_k, output int done_k, output logic [1:0] done_v,
                         output logic [1:0] grant_v, output logic [2*W-1:0] res_v,
                         output int grant_bad, output int tail_bad);
    done_k = -1; done_v = 2'b00; grant_v = 2'b00; res_v = '0;
    grant_bad = 0; tail_bad = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge Clock);
      if (k == 1) grant_v = oGrant;
      if (k == drop_k) begin
        iReq = 2'b00;
        iA0  = ~iA0;
        iB0  = iB0 ^ 16'h1234;
        iA1  = ~iA1;
      end
      if (done_k < 0) begin
        if (oGrant !== grant_v || oBusy !== 1'b1) grant_bad++;
        if (oDone !== 2'b00) begin
          done_k = k;
          done_v = oDone;
          res_v  = oResult;
        end
      end else begin
        if (oDone !== 2'b00 || oGrant !== 2'b00 || oBusy !== 1'b0) tail_bad++;
        break;
      end
    end
  endtask

  task automatic single_op(input string name, input logic [1:0] req, input int drop_k);
    int dk, gb, tb;
    logic [1:0] dv, gv;
    logic [2*W-1:0] rv, exp_r;
    int win;
    win = ref_winner(req);
    exp_r = (win == 0) ? ref_mul(iA0, iB0, iSigned[0]) : ref_mul(iA1, iB1, iSigned[1]);
    iReq = req;
    observe(drop_k, dk, dv, gv, rv, gb, tb);
    iReq = 2'b00;
    model_last = win;
    checks++;
    if (dk !== LAT) begin
      errors++; $display("FAIL %s latency: got %0d required %0d", name, dk, LAT);
    end
    checks++;
    if (dv !== (2'b01 << win)) begin
      errors++; $display("FAIL %s done: got %b required %b", name, dv, 2'b01 << win);
    end
    checks++;
    if (gv !== (2'b01 << win) || gb != 0) begin
      errors++; $display("FAIL %s grant: got %b (%0d bad cycles) required %b", name, gv, gb, 2'b01 << win);
    end
    checks++;
    if (rv !== exp_r) begin
      errors++; $display("FAIL %s result: got %h required %h", name, rv, exp_r);
    end
    checks++;
    if (tb != 0) begin
      errors++; $display("FAIL %s return_idle: got %0d bad required 0", name, tb);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (oGrant !== 2'b00 || oBusy !== 1'b0 || oDone !== 2'b00 || oResult !== '0) begin
      errors++;
      $display("FAIL reset_state: got grant=%b busy=%b done=%b result=%h required all zero",
               oGrant, oBusy, oDone, oResult);
    end
  endtask

  task automatic test_unsigned();
    iA0 = 16'hFFFF; iB0 = 16'hFFFF; iSigned = 2'b00;
    single_op("unsigned_max", 2'b01, 0);
    checks++;
    if (oResult !== 32'hFFFE0001) begin
      errors++; $display("FAIL unsigned_const: got %h required fffe0001", oResult);
    end
    iA0 = 16'h0000; iB0 = 16'h1234;
    single_op("unsigned_zero", 2'b01, 0);
  endtask

  task automatic test_signed();
    logic [2*W-1:0] held;
    iA1 = 16'hFFFD; iB1 = 16'h0007; iSigned = 2'b10;
    single_op("signed_neg", 2'b10, 0);
    checks++;
    if (oResult !== 32'hFFFFFFEB) begin
      errors++; $display("FAIL signed_const: got %h required ffffffeb", oResult);
    end
    held = 32'hFFFFFFEB;
    repeat (3) @(negedge Clock);
    checks++;
    if (oResult !== held) begin
      errors++; $display("FAIL result_hold: got %h required %h", oResult, held);
    end
  endtask

  task automatic test_signed_min();
    iA0 = 16'h8000; iB0 = 16'h8000; iSigned = 2'b01;
    single_op("signed_min", 2'b01, 0);
    checks++;
    if (oResult !== 32'h40000000) begin
      errors++; $display("FAIL signed_min_const: got %h required 40000000", oResult);
    end
  endtask

  task automatic test_back_to_back();
    int dk, gb, tb, win;
    logic [1:0] dv, gv;
    logic [2*W-1:0] rv, exp_r;
    Reset = 1'b0;
    iA0 = 16'($urandom); iB0 = 16'($urandom);
    iA1 = 16'($urandom); iB1 = 16'($urandom);
    iSigned = 2'($urandom);
    iReq = 2'b11;
    model_last = 1;
    @(negedge Clock);
    Reset = 1'b1;
    for (int n = 0; n < 4; n++) begin
      win = ref_winner(2'b11);
      exp_r = (win == 0) ? ref_mul(iA0, iB0, iSigned[0]) : ref_mul(iA1, iB1, iSigned[1]);
      observe(0, dk, dv, gv, rv, gb, tb);
      model_last = win;
      checks++;
      if (dk !== LAT || dv !== (2'b01 << win) || gv !== (2'b01 << win) || gb != 0 || tb != 0) begin
        errors++;
        $display("FAIL contention_%0d: got lat=%0d done=%b grant=%b bad=%0d/%0d required lat=%0d owner=%0d",
                 n, dk, dv, gv, gb, tb, LAT, win);
      end
      checks++;
      if (rv !== exp_r) begin
        errors++; $display("FAIL contention_result_%0d: got %h required %h", n, rv, exp_r);
      end
    end
    iReq = 2'b00;
    @(negedge Clock);
  endtask

  task automatic test_reset_mid_run();
    int seen;
    iA0 = 16'h0123; iB0 = 16'h0456; iSigned = 2'b00;
    iReq = 2'b01;
    repeat (8) @(negedge Clock);
    #2 Reset = 1'b0;
    #1;
    checks++;
    if (oGrant !== 2'b00 || oBusy !== 1'b0 || oDone !== 2'b00 || oResult !== '0) begin
      errors++;
      $display("FAIL reset_mid_run: got grant=%b busy=%b done=%b result=%h required all zero",
               oGrant, oBusy, oDone, oResult);
    end
    iReq = 2'b00;
    @(negedge Clock);
    Reset = 1'b1;
    model_last = 1;
    seen = 0;
    repeat (25) begin
      @(negedge Clock);
      if (oDone !== 2'b00 || oBusy !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL reset_no_done: got %0d active cycles required 0", seen);
    end
    iA1 = 16'h7FFF; iB1 = 16'h8001; iSigned = 2'b10;
    single_op("after_reset", 2'b10, 0);
  endtask

  task automatic test_early_drop();
    iA0 = 16'($urandom); iB0 = 16'($urandom); iSigned = 2'b00;
    single_op("early_drop", 2'b01, 3);
  endtask

  task automatic test_random();
    logic [1:0] req;
    for (int n = 0; n < 8; n++) begin
      req = 2'($urandom_range(1, 3));
      iA0 = (n == 2) ? 16'h0000 : 16'($urandom);
      iB0 = 16'($urandom);
      iA1 = 16'($urandom);
      iB1 = (n == 5) ? 16'h8000 : 16'($urandom);
      iSigned = 2'($urandom);
      single_op($sformatf("random_%0d", n), req, 0);
      if ($urandom_range(0, 1) == 1) @(negedge Clock);
    end
  endtask

  initial begin
    Reset = 1'b0;
    iReq = 2'b00;
    iA0 = '0; iB0 = '0; iA1 = '0; iB1 = '0;
    iSigned = 2'b00;
    repeat (2) @(negedge Clock);
    test_reset();
    Reset = 1'b1;
    test_unsigned();
    test_signed();
    test_signed_min();
    test_back_to_back();
    test_reset_mid_run();
    test_early_drop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
